cond_unit: RTL

- Reader side of the condition-code interface driven by the ALU.
- Holds the architectural CC register (ZF/SF/OF), which the ALU result updates on OPq.
- Evaluates the jXX/cmovXX condition for each accepted instruction and produces a registered Cnd, cmov write enable and branch-mispredict redirect.
- Sits between execute and PC-select/writeback; the fetch side always predicts jXX taken.

---
 rtl/cond_unit.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/cond_unit.sv
// cond_unit: condition-code reader for the ALU/execute stage.
//
// Holds the architectural CC register (ZF/SF/OF). An accepted OPq loads it.
// Every accepted instruction gets a registered result one cycle after it is
// accepted. jXX and cmovXX/rrmovq instructions also get their condition
// evaluated against the CC value held before that edge. The fetch side
// always predicts jXX taken, so a jXX that resolves not-taken raises a
// redirect to its fall-through PC. That redirect is held until fetch
// acknowledges it.
//
// Ports:
//   clk, rst_n                 clock and asynchronous active-low reset
//   in_valid/in_ready          instruction handshake (ready low while a redirect is pending)
//   icode, ifun, valP          instruction code, function/condition code, fall-through PC
//   zf_in, sf_in, of_in        next flags computed from the OPq result
//   out_valid, out_icode       one-cycle result pulse and the icode it belongs to
//   out_cnd, cmov_we, bad_cond evaluated condition, cmov write enable, invalid-condition flag
//   redirect_valid/_pc/_ready  mispredict redirect handshake towards fetch
//   zf, sf, of                 current CC register
//   br_count, mispred_count    saturating jXX statistics
module cond_unit #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       icode,
  input  logic [3:0]       ifun,
  input  logic [63:0]      valP,
  input  logic             zf_in,
  input  logic             sf_in,
  input  logic             of_in,
  output logic             out_valid,
  output logic [3:0]       out_icode,
  output logic             out_cnd,
  output logic             cmov_we,
  output logic             bad_cond,
  output logic             redirect_valid,
  output logic [63:0]      redirect_pc,
  input  logic             redirect_ready,
  output logic             zf,
  output logic             sf,
  output logic             of,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mispred_count
);

  localparam logic [3:0] IC_CMOV = 4'd2;
  localparam logic [3:0] IC_OPQ  = 4'd6;
  localparam logic [3:0] IC_JXX  = 4'd7;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Condition for ifun 0..6. Codes 7..15 are invalid; the caller qualifies them.
  function automatic logic eval_cond(input logic [3:0] fn, input logic z,
                                     input logic s, input logic o);
    logic r;
    case (fn)
      4'd0:    r = 1'b1;
      4'd1:    r = (s ^ o) | z;
      4'd2:    r = s ^ o;
      4'd3:    r = z;
      4'd4:    r = ~z;
      4'd5:    r = ~(s ^ o);
      4'd6:    r = ~(s ^ o) & ~z;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  logic             zf_q, zf_d, sf_q, sf_d, of_q, of_d;
  logic             out_valid_q, out_valid_d;
  logic [3:0]       out_icode_q, out_icode_d;
  logic             out_cnd_q, out_cnd_d;
  logic             cmov_we_q, cmov_we_d;
  logic             bad_cond_q, bad_cond_d;
  logic             redirect_valid_q, redirect_valid_d;
  logic [63:0]      redirect_pc_q, redirect_pc_d;
  logic [CNT_W-1:0] br_count_q, br_count_d;
  logic [CNT_W-1:0] mispred_count_q, mispred_count_d;

  logic accept_s;
  logic cond_s;
  logic bad_s;
  logic is_cc_user_s;

  assign in_ready     = ~redirect_valid_q;
  assign accept_s     = in_valid & ~redirect_valid_q;
  // Evaluated on the pre-edge CC value, so an OPq one cycle earlier is already visible.
  assign cond_s       = eval_cond(ifun, zf_q, sf_q, of_q);
  assign is_cc_user_s = (icode == IC_CMOV) || (icode == IC_JXX);
  assign bad_s        = is_cc_user_s && (ifun > 4'd6);

  // Next-state logic for the CC register, result pulse, redirect and counters.
  always_comb begin
    zf_d             = zf_q;
    sf_d             = sf_q;
    of_d             = of_q;
    out_valid_d      = 1'b0;
    out_icode_d      = out_icode_q;
    out_cnd_d        = out_cnd_q;
    cmov_we_d        = 1'b0;
    bad_cond_d       = 1'b0;
    redirect_valid_d = redirect_valid_q;
    redirect_pc_d    = redirect_pc_q;
    br_count_d       = br_count_q;
    mispred_count_d  = mispred_count_q;

    if (redirect_valid_q && redirect_ready) begin
      redirect_valid_d = 1'b0;
    end else begin
      redirect_valid_d = redirect_valid_q;
    end

    if (accept_s) begin
      out_valid_d = 1'b1;
      out_icode_d = icode;
      bad_cond_d  = bad_s;
      if (is_cc_user_s && !bad_s) begin
        out_cnd_d = cond_s;
      end else begin
        out_cnd_d = 1'b0;
      end
      cmov_we_d = (icode == IC_CMOV) && !bad_s && cond_s;

      if (icode == IC_OPQ) begin
        zf_d = zf_in;
        sf_d = sf_in;
        of_d = of_in;
      end else begin
        zf_d = zf_q;
        sf_d = sf_q;
        of_d = of_q;
      end

      if ((icode == IC_JXX) && !bad_s) begin
        if (br_count_q != CNT_MAX) begin
          br_count_d = br_count_q + CNT_ONE;
        end else begin
          br_count_d = br_count_q;
        end
        // Fetch predicted taken; a not-taken jXX must restart at valP.
        if (!cond_s) begin
          redirect_valid_d = 1'b1;
          redirect_pc_d    = valP;
          if (mispred_count_q != CNT_MAX) begin
            mispred_count_d = mispred_count_q + CNT_ONE;
          end else begin
            mispred_count_d = mispred_count_q;
          end
        end else begin
          redirect_pc_d = redirect_pc_q;
        end
      end else begin
        br_count_d = br_count_q;
      end
    end else begin
      out_valid_d = 1'b0;
    end
  end

  // State register with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zf_q             <= 1'b1;
      sf_q             <= 1'b0;
      of_q             <= 1'b0;
      out_valid_q      <= 1'b0;
      out_icode_q      <= 4'd0;
      out_cnd_q        <= 1'b0;
      cmov_we_q        <= 1'b0;
      bad_cond_q       <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 64'd0;
      br_count_q       <= {CNT_W{1'b0}};
      mispred_count_q  <= {CNT_W{1'b0}};
    end else begin
      zf_q             <= zf_d;
      sf_q             <= sf_d;
      of_q             <= of_d;
      out_valid_q      <= out_valid_d;
      out_icode_q      <= out_icode_d;
      out_cnd_q        <= out_cnd_d;
      cmov_we_q        <= cmov_we_d;
      bad_cond_q       <= bad_cond_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      br_count_q       <= br_count_d;
      mispred_count_q  <= mispred_count_d;
    end
  end

  assign zf             = zf_q;
  assign sf             = sf_q;
  assign of             = of_q;
  assign out_valid      = out_valid_q;
  assign out_icode      = out_icode_q;
  assign out_cnd        = out_cnd_q;
  assign cmov_we        = cmov_we_q;
  assign bad_cond       = bad_cond_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign br_count       = br_count_q;
  assign mispred_count  = mispred_count_q;

endmodule
